// File: rtl/pred_upd_queue_if.sv
// Bundle between execute, the predictor-update queue and the branch predictor.
// The slave modport is the queue's view of the bundle; the master modport is the environment's view.
interface pred_upd_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_pc;
  logic [2:0]      in_type;
  logic            in_taken;
  logic [31:0]     in_target;
  logic            in_mispred;
  logic            upd_valid;
  logic            upd_ready;
  logic [31:0]     upd_pc;
  logic            upd_taken;
  logic            mis_valid;
  logic [31:0]     mis_pc;
  logic [31:0]     mis_target;
  logic [1:0]      mis_type;
  logic [CntW-1:0] count;
  logic [31:0]     mis_cnt;

  modport master (
    output in_valid, in_pc, in_type, in_taken, in_target, in_mispred, upd_ready,
    input  in_ready, upd_valid, upd_pc, upd_taken, mis_valid, mis_pc, mis_target, mis_type,
           count, mis_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_type, in_taken, in_target, in_mispred, upd_ready,
    output in_ready, upd_valid, upd_pc, upd_taken, mis_valid, mis_pc, mis_target, mis_type,
           count, mis_cnt
  );
endinterface

// File: rtl/pred_upd_queue.sv
// Queues resolved conditional branches for predictor direction updates and reports mispredicts.
// Optional macro PRED_UPDQ_BYPASS_EN: an empty queue forwards an incoming conditional record same-cycle.
module pred_upd_queue #(
  parameter int unsigned DEPTH = 8
) (
  input logic             clk,
  input logic             reset,
  pred_upd_queue_if.slave q
);
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam logic [2:0]  TypeCond = 3'b101;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     mem_pc_q [DEPTH];
  logic [31:0]     mem_pc_d [DEPTH];
  logic            mem_taken_q [DEPTH];
  logic            mem_taken_d [DEPTH];
  logic            mis_valid_q, mis_valid_d;
  logic [31:0]     mis_pc_q, mis_pc_d;
  logic [31:0]     mis_target_q, mis_target_d;
  logic [1:0]      mis_type_q, mis_type_d;
  logic [31:0]     mis_cnt_q, mis_cnt_d;

  logic not_full, not_empty, accept, cond_acc, mis_acc, enq, deq;
`ifdef PRED_UPDQ_BYPASS_EN
  logic bypass;
`endif

  assign not_full   = (count_q != CntW'(DEPTH));
  assign not_empty  = (count_q != '0);
  assign accept     = q.in_valid && not_full;
  assign cond_acc   = accept && (q.in_type == TypeCond);
  assign mis_acc    = accept && q.in_mispred;
  assign deq        = not_empty && q.upd_ready;

  assign q.in_ready   = not_full;
  assign q.count      = count_q;
  assign q.mis_valid  = mis_valid_q;
  assign q.mis_pc     = mis_pc_q;
  assign q.mis_target = mis_target_q;
  assign q.mis_type   = mis_type_q;
  assign q.mis_cnt    = mis_cnt_q;

`ifdef PRED_UPDQ_BYPASS_EN
  // A consumed bypass record never touches storage; an unconsumed one is enqueued as usual.
  assign bypass      = cond_acc && !not_empty;
  assign q.upd_valid = not_empty || bypass;
  assign q.upd_pc    = bypass ? q.in_pc : mem_pc_q[rd_ptr_q];
  assign q.upd_taken = bypass ? q.in_taken : mem_taken_q[rd_ptr_q];
  assign enq         = cond_acc && !(bypass && q.upd_ready);
`else
  assign q.upd_valid = not_empty;
  assign q.upd_pc    = mem_pc_q[rd_ptr_q];
  assign q.upd_taken = mem_taken_q[rd_ptr_q];
  assign enq         = cond_acc;
`endif

  always_comb begin
    mem_pc_d    = mem_pc_q;
    mem_taken_d = mem_taken_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (enq) begin
      mem_pc_d[wr_ptr_q]    = q.in_pc;
      mem_taken_d[wr_ptr_q] = q.in_taken;
      wr_ptr_d              = wr_ptr_q + PtrW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(enq) - CntW'(deq);
  end

  always_comb begin
    mis_valid_d  = mis_acc;
    mis_pc_d     = mis_pc_q;
    mis_target_d = mis_target_q;
    mis_type_d   = mis_type_q;
    mis_cnt_d    = mis_cnt_q;
    if (mis_acc) begin
      mis_pc_d     = q.in_pc;
      mis_target_d = q.in_target;
      mis_type_d   = q.in_type[1:0];
      if (mis_cnt_q != '1) begin
        mis_cnt_d = mis_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mis_valid_q  <= 1'b0;
      mis_pc_q     <= '0;
      mis_target_q <= '0;
      mis_type_q   <= '0;
      mis_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mis_valid_q  <= mis_valid_d;
      mis_pc_q     <= mis_pc_d;
      mis_target_q <= mis_target_d;
      mis_type_q   <= mis_type_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  // Storage is left uncleared by reset; the reset pointers make stale entries invisible.
  always_ff @(posedge clk) begin
    mem_pc_q    <= mem_pc_d;
    mem_taken_q <= mem_taken_d;
  end
endmodule
